dma_ctrl: RTL and testbench

Block-copy engine that moves bytes within the data address space through the mem_ctrl read/write ports. While a copy runs it stalls the CPU pipeline and owns those ports. It sits between the CPU pipeline and mem_ctrl and muxes mem_ctrl's readaddr/writeaddr/writedata/write_en between the CPU and itself. The mem_ctrl pause input is not driven by this block and must stay low during a copy.

---
 rtl/ez8_dma_pkg.sv | 21 ++
 rtl/dma_ctrl.sv | 150 +++++++++++++++
 tb/tb_dma_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ez8_dma_pkg.sv
// ez8_dma_pkg
// Shared types and constants for the dma_ctrl block-copy engine.
//   dma_state_t  : copy engine states
//   LEN_W        : width of the length and address counters
//   LEN_ZERO_MAP : effective byte count used when the requested length is 0
package ez8_dma_pkg;

    localparam int LEN_W = 8;

    // A zero length request means a full 256-byte pass, so the remaining
    // counter needs one extra bit to hold it.
    localparam logic [LEN_W:0] LEN_ZERO_MAP = 9'd256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dma_ctrl.sv
// dma_ctrl
// Block-copy engine that moves bytes inside the data address space through
// the mem_ctrl read/write ports. While a copy runs it stalls the CPU and
// owns the memory ports; otherwise the CPU ports pass straight through.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, abort               copy request (sampled in IDLE) / cancel
//   src_addr, dst_addr, len    copy parameters, latched on start (len 0 = 256)
//   cpu_readaddr, cpu_writeaddr, cpu_writedata, cpu_write_en
//                              CPU side of the memory ports
//   mem_readdata               mem_ctrl read data, valid one cycle after address
//   mem_readaddr, mem_writeaddr, mem_writedata, mem_write_en
//                              muxed memory ports towards mem_ctrl
//   cpu_stall, busy            high while a copy is in progress
//   done, aborted              one-cycle completion / cancellation pulses
module dma_ctrl
    import ez8_dma_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] src_addr,
    input  logic [LEN_W-1:0] dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] cpu_readaddr,
    input  logic [LEN_W-1:0] cpu_writeaddr,
    input  logic [LEN_W-1:0] cpu_writedata,
    input  logic             cpu_write_en,
    input  logic [LEN_W-1:0] mem_readdata,
    output logic [LEN_W-1:0] mem_readaddr,
    output logic [LEN_W-1:0] mem_writeaddr,
    output logic [LEN_W-1:0] mem_writedata,
    output logic             mem_write_en,
    output logic             cpu_stall,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    dma_state_t       state_q;
    dma_state_t       state_d;
    logic [LEN_W-1:0] src_q;
    logic [LEN_W-1:0] dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   remaining_q;
    logic             aborted_q;
    logic             copying;

    assign copying = (state_q == PRIME) || (state_q == STREAM);

    // Next-state logic. Abort only matters once the copy has started; in
    // IDLE a simultaneous start simply wins because abort is not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                state_d = abort ? IDLE : STREAM;
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (remaining_q > (LEN_W+1)'(1)) begin
                    state_d = STREAM;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address and length registers. Parameters are copied on start
    // so the caller may change its inputs while the copy runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= copying && abort;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= len;
                    end
                end
                PRIME: begin
                    remaining_q <= (len_q == '0) ? LEN_ZERO_MAP : {1'b0, len_q};
                end
                STREAM: begin
                    src_q       <= src_q + 1'b1;
                    dst_q       <= dst_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory port mux. PRIME issues the first read; each STREAM cycle writes
    // the byte read in the previous cycle and reads ahead one address. The
    // read-ahead is parked at 0 on the last byte.
    always_comb begin
        mem_readaddr  = cpu_readaddr;
        mem_writeaddr = cpu_writeaddr;
        mem_writedata = cpu_writedata;
        mem_write_en  = cpu_write_en;
        case (state_q)
            PRIME: begin
                mem_readaddr  = src_q;
                mem_writeaddr = dst_q;
                mem_writedata = '0;
                mem_write_en  = 1'b0;
            end
            STREAM: begin
                mem_readaddr  = (remaining_q > (LEN_W+1)'(1)) ? src_q + 1'b1 : '0;
                mem_writeaddr = dst_q;
                mem_writedata = mem_readdata;
                mem_write_en  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy      = copying;
    assign cpu_stall = copying;
    assign done      = (state_q == FINISH);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl
// Self-checking bench for dma_ctrl. A behavioural mem_ctrl (one-cycle read
// latency, write-to-read bypass) sits on the memory ports. Expected writes
// are pushed to a scoreboard queue when a copy is launched and compared
// against the writes the DUT actually issues.
module tb_dma_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [7:0] len = '0;
    logic [7:0] cpu_readaddr = '0;
    logic [7:0] cpu_writeaddr = '0;
    logic [7:0] cpu_writedata = '0;
    logic       cpu_write_en = 1'b0;
    logic [7:0] mem_readdata = '0;
    logic [7:0] mem_readaddr;
    logic [7:0] mem_writeaddr;
    logic [7:0] mem_writedata;
    logic       mem_write_en;
    logic       cpu_stall;
    logic       busy;
    logic       done;
    logic       aborted;

    always #5 clk = ~clk;

    dma_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .len           (len),
        .cpu_readaddr  (cpu_readaddr),
        .cpu_writeaddr (cpu_writeaddr),
        .cpu_writedata (cpu_writedata),
        .cpu_write_en  (cpu_write_en),
        .mem_readdata  (mem_readdata),
        .mem_readaddr  (mem_readaddr),
        .mem_writeaddr (mem_writeaddr),
        .mem_writedata (mem_writedata),
        .mem_write_en  (mem_write_en),
        .cpu_stall     (cpu_stall),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    // Behavioural mem_ctrl with a write-to-read bypass.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_writeaddr] <= mem_writedata;
        mem_readdata <= (mem_write_en && mem_writeaddr == mem_readaddr) ?
                        mem_writedata : mem[mem_readaddr];
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t act_q[$];
    wr_t exp_q[$];
    logic [7:0] refm [256];

    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int abort_cnt = 0;
    int stall_err = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (aborted) abort_cnt++;
        if (cpu_stall !== busy) stall_err++;
        if (cpu_stall && mem_write_en) act_q.push_back({mem_writeaddr, mem_writedata});
    end

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        int         exp_busy;
        int         exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [7:0] d);
        cpu_writeaddr = a;
        cpu_writedata = d;
        cpu_write_en  = 1'b1;
        tick();
        cpu_write_en  = 1'b0;
        refm[a] = d;
    endtask

    // Launch a copy and push the first nwr expected writes, modelled as a
    // forward byte-by-byte copy on the reference memory.
    task automatic applyStimulus(input logic [7:0] s_a, input logic [7:0] d_a,
                                 input logic [7:0] l, input int nwr, output int s);
        logic [7:0] ra;
        logic [7:0] wa;
        for (int i = 0; i < nwr; i++) begin
            ra = s_a + 8'(i);
            wa = d_a + 8'(i);
            exp_q.push_back({wa, refm[ra]});
            refm[wa] = refm[ra];
        end
        src_addr = s_a;
        dst_addr = d_a;
        len      = l;
        start    = 1'b1;
        s        = cyc;
        tick();
        start    = 1'b0;
        src_addr = 8'hEE;
        dst_addr = 8'hEE;
        len      = 8'h07;
    endtask

    task automatic waitEnd(input string name);
        int d0;
        int a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        for (int n = 0; n < 300; n++) begin
            if (done_cnt != d0 || abort_cnt != a0) break;
            tick();
        end
        if (done_cnt == d0 && abort_cnt == a0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: got no done/aborted, expected one within 300 cycles", name);
        end
        tick();
    endtask

    task automatic compareWrites(input string name);
        wr_t a;
        wr_t e;
        checkOutput($sformatf("%s write count", name), act_q.size(), exp_q.size());
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            checkOutput($sformatf("%s write addr", name), a.addr, e.addr);
            checkOutput($sformatf("%s write data @%0h", name, e.addr), a.data, e.data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic checkMem(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (bad < 0 && mem[i] !== refm[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("[TB] FAIL %s memory @%0h: got 0x%0h, expected 0x%0h",
                     name, bad, mem[bad], refm[bad]);
        end
    endtask

    initial begin
        int s;
        int b0;
        int d0;
        int a0;
        logic [7:0] pt [4][4];

        vecs[0] = '{8'h20, 8'h40, 8'd4, 5, 6};
        vecs[1] = '{8'h10, 8'h10, 8'd0, 257, 258};
        vecs[2] = '{8'h30, 8'h31, 8'd3, 4, 5};
        vecs[3] = '{8'hFD, 8'h02, 8'd5, 6, 7};
        vecs[4] = '{8'h60, 8'h61, 8'd1, 2, 3};

        pt[0] = '{8'h12, 8'h00, 8'h00, 8'h0};
        pt[1] = '{8'hA5, 8'h34, 8'h56, 8'h0};
        pt[2] = '{8'hFF, 8'hF0, 8'h9C, 8'h1};
        pt[3] = '{8'h01, 8'h80, 8'h3D, 8'h0};

        // Reset state
        cpu_readaddr = 8'h3C;
        tick();
        tick();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cpu_stall", cpu_stall, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset aborted", aborted, 0);
        checkOutput("reset readaddr passthrough", mem_readaddr, 8'h3C);
        reset = 1'b0;
        tick();

        // Idle pass-through table
        for (int i = 0; i < 4; i++) begin
            cpu_readaddr  = pt[i][0];
            cpu_writeaddr = pt[i][1];
            cpu_writedata = pt[i][2];
            cpu_write_en  = pt[i][3][0];
            #1;
            checkOutput("idle readaddr", mem_readaddr, pt[i][0]);
            checkOutput("idle writeaddr", mem_writeaddr, pt[i][1]);
            checkOutput("idle writedata", mem_writedata, pt[i][2]);
            checkOutput("idle write_en", mem_write_en, pt[i][3]);
            tick();
            cpu_write_en = 1'b0;
        end

        // Preload memory through the CPU path
        for (int i = 0; i < 256; i++) cpuWrite(8'(i), 8'(i * 7 + 3));
        cpuWrite(8'h20, 8'h11);
        cpuWrite(8'h21, 8'h22);
        cpuWrite(8'h22, 8'h33);
        cpuWrite(8'h23, 8'h44);
        cpuWrite(8'h30, 8'hAA);
        checkMem("preload");

        // Table of normal copies
        for (int v = 0; v < 5; v++) begin
            b0 = busy_cnt;
            applyStimulus(vecs[v].src, vecs[v].dst, vecs[v].len,
                          (vecs[v].len == 0) ? 256 : int'(vecs[v].len), s);
            waitEnd($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d busy cycles", v), busy_cnt - b0, vecs[v].exp_busy);
            checkOutput($sformatf("vec%0d done offset", v), done_cyc - s, vecs[v].exp_done);
            compareWrites($sformatf("vec%0d", v));
            checkMem($sformatf("vec%0d", v));
        end
        checkOutput("copy 0x43", mem[8'h43], 8'h44);
        checkOutput("overlap 0x33", mem[8'h33], 8'hAA);

        // Abort on the second STREAM cycle of an 8-byte copy
        cpu_readaddr = 8'h5A;
        d0 = done_cnt;
        a0 = abort_cnt;
        applyStimulus(8'h80, 8'hA0, 8'd8, 2, s);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort pulse", aborted, 1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort passthrough", mem_readaddr, 8'h5A);
        checkOutput("abort write_en", mem_write_en, 0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("abort done count", done_cnt - d0, 0);
        checkOutput("abort pulse count", abort_cnt - a0, 1);
        compareWrites("abort");
        checkMem("abort");

        // Abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("idle abort", aborted, 0);

        // Start and abort together in IDLE: start wins
        abort = 1'b1;
        applyStimulus(8'h70, 8'h78, 8'd2, 2, s);
        abort = 1'b0;
        waitEnd("start+abort");
        checkOutput("start+abort done offset", done_cyc - s, 4);
        compareWrites("start+abort");
        checkMem("start+abort");

        // Start while busy is ignored
        b0 = busy_cnt;
        d0 = done_cnt;
        applyStimulus(8'h90, 8'hB0, 8'd4, 4, s);
        tick();
        src_addr = 8'h00;
        dst_addr = 8'hC8;
        len      = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        waitEnd("restart");
        for (int i = 0; i < 8; i++) tick();
        checkOutput("restart busy cycles", busy_cnt - b0, 5);
        checkOutput("restart done count", done_cnt - d0, 1);
        compareWrites("restart");
        checkMem("restart");

        // Reset during STREAM
        d0 = done_cnt;
        a0 = abort_cnt;
        applyStimulus(8'hC0, 8'hD0, 8'd8, 1, s);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset cpu_stall", cpu_stall, 0);
        checkOutput("mid reset done", done, 0);
        checkOutput("mid reset aborted", aborted, 0);
        checkOutput("mid reset write_en", mem_write_en, 0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("mid reset done count", done_cnt - d0, 0);
        checkOutput("mid reset abort count", abort_cnt - a0, 0);
        compareWrites("mid reset");
        checkMem("mid reset");

        // CPU write in the same cycle start is sampled
        cpu_writeaddr = 8'h50;
        cpu_writedata = 8'h77;
        cpu_write_en  = 1'b1;
        refm[8'h50] = 8'h77;
        applyStimulus(8'h50, 8'h58, 8'd2, 2, s);
        cpu_write_en  = 1'b0;
        waitEnd("cpu write");
        checkOutput("cpu write landed", mem[8'h50], 8'h77);
        checkOutput("cpu write copied", mem[8'h58], 8'h77);
        compareWrites("cpu write");
        checkMem("cpu write");

        checkOutput("stall equals busy", stall_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
